// File: rtl/ntt_butterfly_pipe_pkg.sv
// Shared Kyber constants and types for the NTT butterfly datapath.
// Coefficients are 16-bit signed, Montgomery products are 32-bit signed.
package ntt_butterfly_pipe_pkg;

  localparam int KYBER_Q = 3329;
  localparam int QINV    = -3327;
  localparam int COEF_W  = 16;
  localparam int PROD_W  = 32;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  typedef enum logic {
    MODE_CT = 1'b0,
    MODE_GS = 1'b1
  } bfly_mode_e;

  // 16-bit two's-complement wrap of a sum or difference of two coefficients
  function automatic coef_t coef_add(input coef_t x, input coef_t y);
    return x + y;
  endfunction

  function automatic coef_t coef_sub(input coef_t x, input coef_t y);
    return x - y;
  endfunction

endpackage

// File: rtl/ntt_butterfly_pipe_mont_reduce.sv
// Combinational Montgomery reduction: returns a*2^-16 mod q in (-q, q)
// for a 32-bit signed input, matching the Kyber reference montgomery_reduce.
module mont_reduce
  import ntt_butterfly_pipe_pkg::*;
#(
  parameter int KYBER_Q = ntt_butterfly_pipe_pkg::KYBER_Q,
  parameter int QINV    = ntt_butterfly_pipe_pkg::QINV
) (
  input  logic signed [PROD_W-1:0] i_a,
  output logic signed [COEF_W-1:0] o_r
);

  coef_t w_t;
  prod_t w_tq;
  prod_t w_diff;

  // Only the low half of a*QINV matters; it makes the low 16 bits of a - t*q zero.
  assign w_t    = coef_t'(i_a[COEF_W-1:0] * 16'(QINV));
  assign w_tq   = 32'(w_t) * 32'(KYBER_Q);
  assign w_diff = i_a - w_tq;
  assign o_r    = w_diff[PROD_W-1:COEF_W];

endmodule

// File: rtl/ntt_butterfly_pipe.sv
// Three-stage CT/GS NTT butterfly with valid/ready flow control:
// S1 pre-add (GS), S2 twiddle multiply, S3 Montgomery reduce and post-add (CT).
module ntt_butterfly_pipe
  import ntt_butterfly_pipe_pkg::*;
#(
  parameter int KYBER_Q = ntt_butterfly_pipe_pkg::KYBER_Q,
  parameter int QINV    = ntt_butterfly_pipe_pkg::QINV
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic                     i_mode,
  input  logic signed [COEF_W-1:0] i_a,
  input  logic signed [COEF_W-1:0] i_b,
  input  logic signed [COEF_W-1:0] i_zeta,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic signed [COEF_W-1:0] o_out0,
  output logic signed [COEF_W-1:0] o_out1
);

  logic       r_v1, r_v2, r_v3;
  bfly_mode_e r_mode1, r_mode2;
  coef_t      r_zeta1, r_x1, r_y1;
  coef_t      r_x2;
  prod_t      r_prod2;
  coef_t      r_out0, r_out1;
  logic [1:0] r_occ;

  logic       w_ld1, w_ld2, w_ld3;
  logic       w_in_xfer, w_out_xfer;
  bfly_mode_e w_mode_in;
  coef_t      w_x_in, w_y_in;
  prod_t      w_prod;
  coef_t      w_t;
  coef_t      w_out0_next, w_out1_next;

  // A stage loads when it is empty or its content moves on this cycle.
  assign w_ld3 = !r_v3 || i_out_ready;
  assign w_ld2 = !r_v2 || w_ld3;
  assign w_ld1 = !r_v1 || w_ld2;

  assign o_in_ready  = w_ld1;
  assign o_out_valid = r_v3;
  assign o_out0      = r_out0;
  assign o_out1      = r_out1;

  assign w_in_xfer  = i_in_valid && w_ld1;
  assign w_out_xfer = r_v3 && i_out_ready;

  assign w_mode_in = bfly_mode_e'(i_mode);

  always_comb begin
    w_x_in = i_a;
    w_y_in = i_b;
    if (w_mode_in == MODE_GS) begin
      w_x_in = coef_add(i_a, i_b);
      w_y_in = coef_sub(i_b, i_a);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1    <= 1'b0;
      r_mode1 <= MODE_CT;
      r_zeta1 <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
    end else if (w_ld1) begin
      r_v1 <= i_in_valid;
      if (i_in_valid) begin
        r_mode1 <= w_mode_in;
        r_zeta1 <= i_zeta;
        r_x1    <= w_x_in;
        r_y1    <= w_y_in;
      end
    end
  end

  assign w_prod = 32'(r_zeta1) * 32'(r_y1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v2    <= 1'b0;
      r_mode2 <= MODE_CT;
      r_x2    <= '0;
      r_prod2 <= '0;
    end else if (w_ld2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_mode2 <= r_mode1;
        r_x2    <= r_x1;
        r_prod2 <= w_prod;
      end
    end
  end

  mont_reduce #(
    .KYBER_Q (KYBER_Q),
    .QINV    (QINV)
  ) u_mont_reduce (
    .i_a (r_prod2),
    .o_r (w_t)
  );

  always_comb begin
    w_out0_next = r_x2;
    w_out1_next = w_t;
    if (r_mode2 == MODE_CT) begin
      w_out0_next = coef_add(r_x2, w_t);
      w_out1_next = coef_sub(r_x2, w_t);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v3   <= 1'b0;
      r_out0 <= '0;
      r_out1 <= '0;
    end else if (w_ld3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_out0 <= w_out0_next;
        r_out1 <= w_out1_next;
      end
    end
  end

  // Items in flight; never exceeds the three stage slots.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_occ <= 2'd0;
    end else begin
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  a_occ_matches_valids : assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
      r_occ == (2'(r_v1) + 2'(r_v2) + 2'(r_v3))
  );

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Self-checking bench for ntt_butterfly_pipe: directed vectors, stall, reset
// and a randomized CT/GS stream against a Kyber reference-style model.
module tb_ntt_butterfly_pipe;

  typedef struct {
    logic              m;
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic signed [15:0] z;
  } item_t;

  typedef struct {
    logic signed [15:0] o0;
    logic signed [15:0] o1;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic               mode;
  logic signed [15:0] a, b, zeta;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out0, out1;

  ntt_butterfly_pipe dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_mode      (mode),
    .i_a         (a),
    .i_b         (b),
    .i_zeta      (zeta),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out0      (out0),
    .o_out1      (out1)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  logic acc_flag;
  exp_t q[$];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Kyber reference fqmul: montgomery_reduce((int32)z * x)
  function automatic logic signed [15:0] fqmul(input logic signed [15:0] z,
                                               input logic signed [15:0] x);
    int      p;
    shortint t;
    p = int'(z) * int'(x);
    t = shortint'(p * -3327);
    return 16'((p - int'(t) * 3329) >>> 16);
  endfunction

  function automatic exp_t model(input item_t it);
    exp_t               e;
    logic signed [15:0] t, s, d;
    if (it.m == 1'b0) begin
      t    = fqmul(it.z, it.b);
      e.o0 = it.a + t;
      e.o1 = it.a - t;
    end else begin
      s    = it.a + it.b;
      d    = it.b - it.a;
      e.o0 = s;
      e.o1 = fqmul(it.z, d);
    end
    return e;
  endfunction

  function automatic logic signed [15:0] rand_coef();
    logic signed [15:0] edges [6];
    edges = '{-16'sd32768, 16'sd32767, 16'sd0, -16'sd1, 16'sd3328, -16'sd3329};
    if ($urandom_range(0, 7) == 0) return edges[$urandom_range(0, 5)];
    return 16'($urandom);
  endfunction

  function automatic item_t rand_item();
    item_t it;
    it.m = 1'($urandom_range(0, 1));
    it.a = rand_coef();
    it.b = rand_coef();
    it.z = rand_coef();
    return it;
  endfunction

  task automatic drive(input item_t it);
    mode = it.m;
    a    = it.a;
    b    = it.b;
    zeta = it.z;
  endtask

  // One clock: sample handshakes mid-cycle, update model, advance past the edge.
  task automatic tick();
    exp_t e;
    item_t it;
    @(negedge clk);
    acc_flag = 1'b0;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", out_valid, 0);
      end else begin
        e = q.pop_front();
        chk("out0", out0, e.o0);
        chk("out1", out1, e.o1);
        n_out++;
      end
    end
    if (in_valid && in_ready) begin
      it.m = mode; it.a = a; it.b = b; it.z = zeta;
      q.push_back(model(it));
      acc_flag = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic m,
                          input logic signed [15:0] da, input logic signed [15:0] db,
                          input logic signed [15:0] dz, input logic signed [15:0] e0,
                          input logic signed [15:0] e1);
    mode = m; a = da; b = db; zeta = dz;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk({tag, "_latency_valid"}, out_valid, (k == 3) ? 1 : 0);
      if (k != 3) @(posedge clk);
    end
    chk({tag, "_out0"}, out0, e0);
    chk({tag, "_out1"}, out1, e1);
    @(posedge clk);
    #1;
    chk({tag, "_drained"}, out_valid, 0);
  endtask

  initial begin
    item_t cur;
    int    fed;
    int    n0;
    int    sent;

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mode = 1'b0; a = '0; b = '0; zeta = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out0", out0, 0);
    chk("reset_out1", out1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    directed("ct_100_1", 1'b0, 16'sd100, 16'sd1, 16'sd2285, 16'sd101, 16'sd99);
    directed("gs_5_7", 1'b1, 16'sd5, 16'sd7, 16'sd2285, 16'sd12, 16'sd2);
    directed("ct_zeta0", 1'b0, -16'sd7, 16'sd1234, 16'sd0, -16'sd7, -16'sd7);

    // Stall: downstream blocked while four items are offered.
    out_ready = 1'b0;
    fed = 0;
    cur = rand_item(); drive(cur); in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (acc_flag) begin
        fed++;
        if (fed < 4) begin cur = rand_item(); drive(cur); end
        else in_valid = 1'b0;
      end
    end
    chk("stall_accepts", fed, 3);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_hold_out0", out0, q[0].o0);
    chk("stall_hold_out1", out1, q[0].o1);
    n0 = n_out;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (q.size() > 0 || in_valid); c++) begin
      tick();
      if (acc_flag) begin fed++; in_valid = 1'b0; end
    end
    chk("stall_released", n_out - n0, 4);

    // Random full-rate stream with random back-pressure.
    n0 = n_out;
    sent = 0;
    cur = rand_item(); drive(cur); in_valid = 1'b1;
    for (int c = 0; c < 3000 && sent < 200; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc_flag) begin
        sent++;
        if (sent < 200) begin cur = rand_item(); drive(cur); end
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() > 0; c++) tick();
    chk("stream_count", n_out - n0, 200);

    // Reset with three items in flight.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cur = rand_item(); drive(cur); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("prereset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", out_valid, 0);
    chk("async_reset_out0", out0, 0);
    chk("async_reset_in_ready", in_ready, 1);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("post_reset_no_stale", out_valid, 0);
      @(posedge clk);
      #1;
    end
    directed("post_reset_ct", 1'b0, 16'sd100, 16'sd1, 16'sd2285, 16'sd101, 16'sd99);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/ntt_butterfly_pipe.md
NTT_BUTTERFLY_PIPE -- requirements
Module: ntt_butterfly_pipe

Interface
REQ-001 Parameter KYBER_Q, default 3329, modulus q.
REQ-002 Parameter QINV, default -3327, q^-1 mod 2^16 (signed 16-bit), passed to the reduction sub-module.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand set on a/b/zeta/mode is valid.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 mode  input  1  0 = Cooley-Tukey (forward NTT), 1 = Gentleman-Sande (inverse NTT).
REQ-008 a, b, zeta  input  16 each  signed coefficients and twiddle factor in Montgomery domain.
REQ-009 out_valid  output  1  out0/out1 hold a valid result.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 out0, out1  output  16 each  signed butterfly results.

Function
REQ-012 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-013 Three register stages S1/S2/S3, each with its own valid bit; latency 3 cycles from accept to out_valid when unstalled; throughput 1 per cycle.
REQ-014 S1 (GS): capture sum = a+b and diff = b-a, both 16-bit two's-complement wrap; (CT): capture a and b unchanged; mode and zeta always captured.
REQ-015 S2: capture the 32-bit signed product zeta*b (CT) or zeta*diff (GS), plus a (CT) or sum (GS).
REQ-016 S3: t = montgomery reduction of the S2 product, t in (-q, q), t congruent to product*2^-16 mod q.
REQ-017 CT outputs: out0 = a+t, out1 = a-t, 16-bit wrap; GS outputs: out0 = sum, out1 = t; no Barrett reduction in this block.
REQ-018 Each stage advances when the next stage is empty or advancing (bubble collapse); S3 advances when out_ready or S3 is empty.
REQ-019 in_ready = !S1.valid || S1 advancing; combinational from out_ready through the stage-advance chain only.
REQ-020 Stalled stage (out_valid && !out_ready) holds its data and valid unchanged; out0/out1 stable until the transfer.
REQ-021 Simultaneous in/out transfer with all stages full: all stages shift, no item lost or duplicated.
REQ-022 Results leave in acceptance order; mode travels with its item, so mixed CT/GS streams are legal back-to-back.
REQ-023 Output counter occ[1:0] internal only; no overflow, at most 3 items in flight.

Reset
REQ-024 rst_n low clears all stage valid bits asynchronously: out_valid = 0, in_ready = 1 after release.
REQ-025 Data registers reset to 0; out0 = out1 = 0 during reset.
REQ-026 Reset mid-operation discards all in-flight items; no result of a pre-reset item appears afterwards.

Structure
REQ-027 KYBER_Q, QINV, and the 16/32-bit coefficient/product widths belong in the shared kyber package.
REQ-028 The S3 reduction is the existing combinational montgomery reducer (mont_reduce, 32-bit signed in, 16-bit signed out) instantiated once; no other sub-module.

Verification
REQ-029 CT, a=100, b=1, zeta=2285 -> 3 cycles later out0=101, out1=99.
REQ-030 GS, a=5, b=7, zeta=2285 -> out0=12, out1=2.
REQ-031 CT, a=-7, b=1234, zeta=0 -> out0=-7, out1=-7.
REQ-032 Stall: out_ready=0 for 6 cycles while feeding 4 items -> in_ready drops after 3 accepts, then results are released in order, each once.
REQ-033 Streaming: 200 random CT/GS items at full rate with random out_ready -> every result matches a C model of the Kyber reference fqmul/butterfly, in order.
REQ-034 Reset asserted with 3 items in flight -> out_valid=0 immediately, and no stale result appears after release.
